// File: rtl/vga_scan.sv
// 640x480@60 raster timing generator: pixel coordinates, syncs, video_on and frame tick.
// Define VGA_CLKDIV_EN to derive the pixel enable from a /4 divider of clk.
module vga_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] scan_x,
  output logic [8:0] scan_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_PRE_FT = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_en;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_last, v_last;

  logic [9:0] scan_x_q;
  logic [8:0] scan_y_q;
  logic       video_on_q, hsync_q, vsync_q, frame_tick_q;

`ifdef VGA_CLKDIV_EN
  logic [1:0] div_q;
  logic       tick_q;

  // tick_q is registered one clk ahead so it lines up with div_q wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 2'd0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_q + 2'd1;
      tick_q <= (div_q == 2'd2);
    end
  end

  assign pix_en   = tick_q;
  assign pix_tick = tick_q;
`else
  assign pix_en   = 1'b1;
  assign pix_tick = rst_n;
`endif

  assign h_last = (h_cnt_q == H_MAX);
  assign v_last = (v_cnt_q == V_MAX);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_last) begin
        h_cnt_d = 10'd0;
        v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Outputs sample the pre-advance counter on each enable, so they trail by one pixel
  // and every decoded field comes from the same counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q      <= 10'd0;
      v_cnt_q      <= 10'd0;
      scan_x_q     <= 10'd0;
      scan_y_q     <= 9'd0;
      video_on_q   <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_tick_q <= pix_en && h_last && (v_cnt_q == V_PRE_FT);
      if (pix_en) begin
        scan_x_q   <= h_cnt_q;
        scan_y_q   <= v_cnt_q[8:0];
        video_on_q <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_q    <= !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vsync_q    <= !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
      end
    end
  end

  assign scan_x     = scan_x_q;
  assign scan_y     = scan_y_q;
  assign video_on   = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan.sv
// Scoreboard bench for vga_scan: a reduced-timing instance for full frames plus a
// default-timing instance for the first lines; expected outputs derive from enable counts.
module tb_vga_scan;

`ifdef VGA_CLKDIV_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  // reduced geometry: 30 x 19 = 570 pixels per frame
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int STOT = (SHA+SHF+SHS+SHB) * (SVA+SVF+SVS+SVB);

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       ft;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0] sx_s, sx_d;
  logic [8:0] sy_s, sy_d;
  logic von_s, hs_s, vs_s, pt_s, ft_s;
  logic von_d, hs_d, vs_d, pt_d, ft_d;

  vga_scan #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .scan_x(sx_s), .scan_y(sy_s), .video_on(von_s),
    .hsync(hs_s), .vsync(vs_s), .pix_tick(pt_s), .frame_tick(ft_s)
  );

  vga_scan u_d (
    .clk(clk), .rst_n(rst_n), .scan_x(sx_d), .scan_y(sy_d), .video_on(von_d),
    .hsync(hs_d), .vsync(vs_d), .pix_tick(pt_d), .frame_tick(ft_d)
  );

  obs_t obs_s, obs_d;
  assign obs_s = '{x:sx_s, y:sy_s, von:von_s, hs:hs_s, vs:vs_s, pt:pt_s, ft:ft_s};
  assign obs_d = '{x:sx_d, y:sy_d, von:von_d, hs:hs_d, vs:vs_d, pt:pt_d, ft:ft_d};

  int checks = 0;
  int passed = 0;
  obs_t q_s[$];
  obs_t q_d[$];

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got x=%0d y=%0d von=%b hs=%b vs=%b pt=%b ft=%b, want x=%0d y=%0d von=%b hs=%b vs=%b pt=%b ft=%b",
                  name, got.x, got.y, got.von, got.hs, got.vs, got.pt, got.ft,
                  exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.pt, exp.ft);
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d want %0d", name, got, exp);
  endtask

  // Output snapshot expected once n pixel enables have occurred; the visible pixel
  // is the (n-1)th of the frame raster, counted row-major.
  function automatic obs_t model(input int n, input bit en, input bit pt,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb);
    int ht, vt, tot, p, h, v;
    obs_t o;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    tot = ht * vt;
    o = '{x:10'd0, y:9'd0, von:1'b0, hs:1'b1, vs:1'b1, pt:pt, ft:1'b0};
    if (n > 0) begin
      p = (n - 1) % tot;
      h = p % ht;
      v = p / ht;
      o.x   = 10'(h);
      o.y   = 9'(v % 512);
      o.von = (h < ha) && (v < va);
      o.hs  = !((h >= ha + hf) && (h < ha + hf + hs));
      o.vs  = !((v >= va + vf) && (v < va + vf + vs));
      o.ft  = en && ((n % tot) == va * ht);
    end
    return o;
  endfunction

  // reference: counts clks since release and pushes the expected post-edge outputs
  initial begin
    int k, n;
    bit en, pt;
    k = 0;
    n = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        n = 0;
        q_s.delete();
        q_d.delete();
      end else begin
        k++;
        en = ((k % P) == 0);
        pt = (P == 1) ? 1'b1 : ((k % P) == P - 1);
        if (en) n++;
        q_s.push_back(model(n, en, pt, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
        q_d.push_back(model(n, en, pt, 640, 16, 96, 48, 480, 10, 2, 33));
      end
    end
  end

  // monitor: the DUT presents a fresh output set every clk
  initial begin
    forever begin
      @(negedge clk);
      if (q_s.size() > 0) chk("scan_small", obs_s, q_s.pop_front());
      if (q_d.size() > 0) chk("scan_vga", obs_d, q_d.pop_front());
    end
  end

  obs_t rst_exp;

  initial begin
    int ft_cnt;
    rst_exp = '{x:10'd0, y:9'd0, von:1'b0, hs:1'b1, vs:1'b1, pt:1'b0, ft:1'b0};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_small", obs_s, rst_exp);
    chk("reset_vga", obs_d, rst_exp);
    #1 rst_n = 1'b1;

    // two full reduced frames must carry exactly two frame ticks
    ft_cnt = 0;
    repeat (2 * STOT * P) begin
      @(negedge clk);
      #1;
      if (ft_s) ft_cnt++;
    end
    chk_int("frame_tick_count", ft_cnt, 2);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(50, 1500)) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_small", obs_s, rst_exp);
      chk("midreset_vga", obs_d, rst_exp);
      repeat ($urandom_range(1, 5)) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat ((STOT + 130) * P) @(posedge clk);
    end

    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan.md
# vga_scan

Raster timing generator that produces the pixel coordinates consumed by the sprite renderers (board, cross, nought) and the VGA sync outputs. Drives 640x480@60 Hz timing from a single system clock, presents registered `scan_x`/`scan_y` plus `video_on`, and emits a once-per-frame tick so game logic can update state during vertical blanking. Sits between the clock/reset root and the pixel-colour mux at the top level.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync pulse width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width (lines)
- `V_BP`, 33: vertical back porch (lines)

- `clk` in 1: system clock, 100 MHz with divider enabled
- `rst_n` in 1: asynchronous, active-low reset
- `scan_x` out 10: current horizontal pixel index
- `scan_y` out 9: current vertical line index (low 9 bits)
- `video_on` out 1: high when `scan_x < H_ACTIVE` and line `< V_ACTIVE`
- `hsync` out 1: horizontal sync, active-low
- `vsync` out 1: vertical sync, active-low
- `pix_tick` out 1: one-clk pulse marking each pixel advance
- `frame_tick` out 1: one-clk pulse on entry to line `V_ACTIVE`, pixel 0

## Operation
- Internal `h_cnt` (10 b) runs 0..H_TOTAL-1 (H_TOTAL = 800), advancing only on pixel enable; wraps to 0 and increments `v_cnt`.
- `v_cnt` (10 b) runs 0..V_TOTAL-1 (V_TOTAL = 525); wraps to 0 at end of frame (h and v wrap in the same enable).
- `scan_x` = `h_cnt`; `scan_y` = `v_cnt[8:0]`. Coordinates are meaningful only while `video_on`=1; consumers gate `draw` with `video_on`.
- `hsync` = 0 for `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC` (656..751), else 1.
- `vsync` = 0 for `V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC` (490..491), else 1.
- `frame_tick` asserted for exactly one clk, on the clk where counters become (h=0, v=V_ACTIVE); never on any other transition.
- No handshake: block free-runs from reset release.
- All outputs registered; outputs decoded from the same counter state, so `scan_x`, `scan_y`, `video_on`, `hsync`, `vsync` are mutually aligned (no skew between them).

## Timing
- Reset (`rst_n`=0, asynchronous): `h_cnt`=0, `v_cnt`=0, divider=0, `scan_x`=0, `scan_y`=0, `video_on`=0, `hsync`=1, `vsync`=1, `pix_tick`=0, `frame_tick`=0.
- First pixel enable after release: outputs present (0,0) with `video_on`=1 on the following clk; outputs lag counter state by 1 clk.
- Reset asserted mid-line/mid-frame: all state returns to reset values immediately; no partial sync pulse is extended.
- Counter widths: H_TOTAL and V_TOTAL must be ≤ 1024; no overflow beyond wrap point is permitted.
- Outputs change only on clks where `pix_tick`=1 (except reset); they hold for the full pixel period between enables.

## Configuration
- `VGA_CLKDIV_EN` defined: internal 2-bit divider; pixel enable every 4th clk (25 MHz from 100 MHz). `pix_tick` high one clk in four; first enable on 4th clk after reset release.
- `VGA_CLKDIV_EN` undefined: `clk` is the pixel clock; pixel enable every clk after reset release; `pix_tick` tied high (1) except held 0 during reset.

## Test plan
- Reset release, divider enabled -> `pix_tick` period exactly 4 clks; `scan_x` reaches 639 after 640 enables with `video_on`=1, then 640 -> `video_on`=0.
- Line timing -> `hsync` falls when `scan_x`=656, rises at 752; line length 800 enables; `scan_y` increments as `scan_x` wraps 799 -> 0.
- Frame timing -> `vsync` low only for `scan_y` 490 and 491; frame length 525 x 800 = 420000 enables; `v_cnt` wraps 524 -> 0 coincident with `h_cnt` 799 -> 0.
- `frame_tick` -> exactly one pulse per frame, at (h=0, v=480); zero pulses elsewhere over 2 full frames.
- Reset mid-frame at (h=300, v=200) -> all outputs at reset values within the same clk as `rst_n` falling; after release, sequence restarts at (0,0).
- Divider disabled -> `pix_tick`=1 every clk, frame length 420000 clks, sync positions as above.
